// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared types and helpers for the bit-to-byte receive path.
//   RxState        : deserialiser FSM states
//   RxBitCount     : bit position within the current byte (0..8)
//   PARITY_BIT_IDX : position of the ISO/IEC 14443A odd-parity bit
//   odd_parity_ok  : true when data byte plus parity bit hold an odd number of 1s
// -----------------------------------------------------------------------------
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    ERR  = 2'd2
  } RxState;

  typedef logic [3:0] RxBitCount;

  localparam RxBitCount PARITY_BIT_IDX = 4'd8;

  // The XOR of all nine bits is 1 exactly when the number of ones is odd.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte,
                                         input logic       parity_bit);
    return (^{data_byte, parity_bit}) == 1'b1;
  endfunction

endpackage

// File: rtl/rx_deserialiser_chk.sv
// -----------------------------------------------------------------------------
// rx_deserialiser_chk
// Simulation-only protocol checker for rx_deserialiser, attached with bind.
// Flags eoc arriving together with a data bit while a frame is being received;
// the deserialiser drops that bit.
// Ports: clk, rst_n, the deserialiser inputs and its state register.
// -----------------------------------------------------------------------------
module rx_deserialiser_chk
  import rx_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  input logic   in_soc,
  input logic   in_eoc,
  input logic   in_data_valid,
  input RxState state_r
);

  // eoc with data_valid in RX is an upstream protocol violation.
  always @(posedge clk) begin
    if (rst_n && (state_r == RX) && !in_soc) begin
      assert (!(in_eoc && in_data_valid))
        else $error("rx_deserialiser: eoc with data_valid, bit dropped");
    end
  end

endmodule

// File: rtl/rx_deserialiser.sv
// -----------------------------------------------------------------------------
// rx_deserialiser
// Turns the bit-level receive event stream from the frame decoder into the
// byte-level event stream used by the byte-wide rx consumers. Data bits arrive
// LSB first; after every 8 data bits an odd-parity bit is checked and stripped.
// A frame ending part way through a byte reports the partial byte together
// with its bit count.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_soc / in_eoc   start / end of frame pulses
//   in_error          decode error pulse from upstream
//   in_data_valid     in_data carries a bit this cycle
//   in_data           received bit
//   out_soc/out_eoc   registered start / end of frame pulses
//   out_error         registered error pulse
//   out_data_valid    out_data / out_data_bits are valid this cycle
//   out_data          received byte (partial bytes zero-filled above the count)
//   out_data_bits     valid bits in out_data, 0 means a full byte
//   out_byte_count    full bytes emitted in the current frame (optional)
//
// Optional feature macro: RX_DESERIALISER_BYTE_COUNT_EN adds out_byte_count.
// All outputs appear one cycle after the input cycle that caused them.
// -----------------------------------------------------------------------------
module rx_deserialiser
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_soc,
  input  logic                  in_eoc,
  input  logic                  in_error,
  input  logic                  in_data_valid,
  input  logic                  in_data,
  output logic                  out_soc,
  output logic                  out_eoc,
  output logic                  out_error,
  output logic                  out_data_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_data_bits
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
  ,
  output logic [7:0]            out_byte_count
`endif
);

  // The parity helper and the 3-bit bit count assume byte-wide data.
  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("rx_deserialiser: DATA_WIDTH must be 8");
  end

  RxState                state_r, state_s;
  RxBitCount             count_r, count_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;

  logic                  soc_s, eoc_s, err_s, dv_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [2:0]            bits_s;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      count_r        <= 4'd0;
      shift_r        <= {DATA_WIDTH{1'b0}};
      out_soc        <= 1'b0;
      out_eoc        <= 1'b0;
      out_error      <= 1'b0;
      out_data_valid <= 1'b0;
      out_data       <= {DATA_WIDTH{1'b0}};
      out_data_bits  <= 3'd0;
    end else begin
      state_r        <= state_s;
      count_r        <= count_s;
      shift_r        <= shift_s;
      out_soc        <= soc_s;
      out_eoc        <= eoc_s;
      out_error      <= err_s;
      out_data_valid <= dv_s;
      out_data       <= data_s;
      out_data_bits  <= bits_s;
    end
  end

  // Next state, bit count and shift register.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    shift_s = shift_r;
    if (in_soc) begin
      // soc abandons whatever frame is in progress, from any state.
      state_s = RX;
      count_s = 4'd0;
      shift_s = {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RX: begin
          if (in_eoc) begin
            // eoc wins over a simultaneous data bit; the bit is dropped.
            state_s = IDLE;
            count_s = 4'd0;
            shift_s = {DATA_WIDTH{1'b0}};
          end else if (in_error) begin
            state_s = ERR;
          end else if (in_data_valid) begin
            if (count_r < PARITY_BIT_IDX) begin
              shift_s[count_r[2:0]] = in_data;
              count_s               = count_r + 4'd1;
            end else if (odd_parity_ok(shift_r, in_data)) begin
              // Cleared so a following partial byte starts from zero.
              count_s = 4'd0;
              shift_s = {DATA_WIDTH{1'b0}};
            end else begin
              state_s = ERR;
            end
          end else begin
            state_s = RX;
          end
        end
        ERR: begin
          if (in_eoc) begin
            state_s = IDLE;
          end else begin
            state_s = ERR;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Output event decode; registered by the block above.
  always_comb begin
    soc_s  = 1'b0;
    eoc_s  = 1'b0;
    err_s  = 1'b0;
    dv_s   = 1'b0;
    data_s = {DATA_WIDTH{1'b0}};
    bits_s = 3'd0;
    if (in_soc) begin
      soc_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          soc_s = 1'b0;
        end
        RX: begin
          if (in_eoc) begin
            eoc_s = 1'b1;
            if (in_error) begin
              err_s = 1'b1;
            end else if (count_r == PARITY_BIT_IDX) begin
              // Frame ended where the parity bit was due.
              err_s = 1'b1;
            end else if (count_r != 4'd0) begin
              dv_s   = 1'b1;
              bits_s = count_r[2:0];
              for (int i = 0; i < DATA_WIDTH; i++) begin
                data_s[i] = (i < int'(count_r)) ? shift_r[i] : 1'b0;
              end
            end else begin
              dv_s = 1'b0;
            end
          end else if (in_error) begin
            err_s = 1'b1;
          end else if (in_data_valid && (count_r == PARITY_BIT_IDX)) begin
            if (odd_parity_ok(shift_r, in_data)) begin
              dv_s   = 1'b1;
              data_s = shift_r;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            dv_s = 1'b0;
          end
        end
        ERR: begin
          if (in_eoc) begin
            eoc_s = 1'b1;
          end else begin
            eoc_s = 1'b0;
          end
        end
        default: begin
          soc_s = 1'b0;
        end
      endcase
    end
  end

`ifdef RX_DESERIALISER_BYTE_COUNT_EN
  // Full bytes in the current frame; partial bytes (emitted with eoc) excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_byte_count <= 8'd0;
    end else if (soc_s) begin
      out_byte_count <= 8'd0;
    end else if (dv_s && !eoc_s && (out_byte_count != 8'hFF)) begin
      out_byte_count <= out_byte_count + 8'd1;
    end else begin
      out_byte_count <= out_byte_count;
    end
  end
`endif

endmodule

// File: tb/tb_rx_deserialiser.sv
// -----------------------------------------------------------------------------
// tb_rx_deserialiser
// Directed bench for rx_deserialiser. Each step drives one input cycle, waits
// for the clock edge and inspects the registered outputs 1 time unit later.
// -----------------------------------------------------------------------------
module tb_rx_deserialiser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_soc, in_eoc, in_error, in_data_valid, in_data;
  logic       out_soc, out_eoc, out_error, out_data_valid;
  logic [7:0] out_data;
  logic [2:0] out_data_bits;
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
  logic [7:0] out_byte_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rx_deserialiser #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_soc        (in_soc),
    .in_eoc        (in_eoc),
    .in_error      (in_error),
    .in_data_valid (in_data_valid),
    .in_data       (in_data),
    .out_soc       (out_soc),
    .out_eoc       (out_eoc),
    .out_error     (out_error),
    .out_data_valid(out_data_valid),
    .out_data      (out_data),
    .out_data_bits (out_data_bits)
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
    ,
    .out_byte_count(out_byte_count)
`endif
  );

  bind rx_deserialiser rx_deserialiser_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_soc       (in_soc),
    .in_eoc       (in_eoc),
    .in_data_valid(in_data_valid),
    .state_r      (state_r)
  );

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Flags always compared; byte and bit count only when data is expected.
  task automatic check(input string tag, input logic e_soc, input logic e_eoc,
                       input logic e_err, input logic e_dv,
                       input logic [2:0] e_bits, input logic [7:0] e_data);
    logic [15:0] obs, exp;
    obs = {1'b0, out_soc, out_eoc, out_error, out_data_valid,
           e_dv ? {out_data_bits, out_data} : 11'd0};
    exp = {1'b0, e_soc, e_eoc, e_err, e_dv, e_dv ? {e_bits, e_data} : 11'd0};
    cmp(tag, obs, exp);
  endtask

  task automatic quiet(input string tag);
    check(tag, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic step(input logic soc, input logic eoc, input logic err,
                      input logic dv, input logic d);
    in_soc = soc; in_eoc = eoc; in_error = err; in_data_valid = dv; in_data = d;
    @(posedge clk);
    #1;
    in_soc = 1'b0; in_eoc = 1'b0; in_error = 1'b0; in_data_valid = 1'b0; in_data = 1'b0;
  endtask

  // Sends n bits of v LSB first, expecting no output event for any of them.
  task automatic send_bits(input logic [8:0] v, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, v[i]);
      quiet(tag);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_soc = 1'b0; in_eoc = 1'b0; in_error = 1'b0; in_data_valid = 1'b0; in_data = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    quiet("reset_flags");
    cmp("reset_data", {5'd0, out_data_bits, out_data}, 16'd0);
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
    cmp("reset_byte_count", {8'd0, out_byte_count}, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Stray events while idle are ignored.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    quiet("idle_ignore");

    // REQA short frame: 7 bits of 0x26.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reqa_soc", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h026, 7, "reqa_bits");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reqa_eoc", 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 8'h26);

    // Two full bytes: 0x93 (parity 1), 0x20 (parity 0).
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("two_soc", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h093, 8, "two_b0_bits");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("two_b0_data", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h93);
    send_bits(9'h020, 8, "two_b1_bits");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("two_b1_data", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h20);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("two_eoc", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
    cmp("two_byte_count", {8'd0, out_byte_count}, 16'd2);
`endif

    // Parity failure: 0x93 with parity 0, then 9 ignored bits.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("par_soc", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h093, 8, "par_bits");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par_error", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    send_bits(9'h1FF, 9, "par_ignored");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("par_eoc", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

    // Upstream error after 3 bits.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("uperr_soc", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h005, 3, "uperr_bits");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("uperr_error", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("uperr_eoc", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);

    // Missing parity: eoc after exactly 8 bits.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nopar_soc", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h0A5, 8, "nopar_bits");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nopar_eoc", 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);

    // soc mid-frame restarts reception without an eoc.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resoc_soc1", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h01F, 5, "resoc_bits1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resoc_soc2", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h052, 8, "resoc_bits2");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("resoc_data", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h52);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("resoc_eoc", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
    cmp("resoc_byte_count", {8'd0, out_byte_count}, 16'd1);
`endif

    // Reset asserted mid-frame, with out_soc of a fresh frame still high.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_soc", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    rst_n = 1'b0;
    #1;
    quiet("rst_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_soc2", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    send_bits(9'h00F, 4, "rst_bits");
    rst_n = 1'b0;
    #1;
    quiet("rst_mid_frame");
    cmp("rst_mid_data", {5'd0, out_data_bits, out_data}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Without soc, bits and eoc after reset produce nothing.
    send_bits(9'h1FF, 9, "post_rst_bits");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet("post_rst_eoc");
`ifdef RX_DESERIALISER_BYTE_COUNT_EN
    cmp("post_rst_byte_count", {8'd0, out_byte_count}, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
